// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared constants for the multi-read-port register file.
//   - default register width and address width
//   - 32-bit boot image for r0..r6 (all higher registers boot to zero)
//   - reset_value(): boot word for a register index, trimmed to a given width
// Optional feature macro used by the register file: REG_FILE_BYPASS_EN.
package reg_file_pkg;

   localparam int unsigned DefaultDataW = 32;
   localparam int unsigned DefaultAddrW = 5;

   localparam int unsigned BootWords = 7;

   // Index 0 is the hardwired zero register and is listed only for completeness.
   localparam logic [31:0] BootImage [BootWords] = '{
      32'h0000_0000,
      32'h0000_000F,
      32'h0000_000C,
      32'hFF00_00FF,
      32'h0000_0004,
      32'h7000_0000,
      32'hF000_0000
   };

   // Boot word for register idx. Widths below 32 keep only the low bits; wider
   // registers zero-extend at the call site via a width cast.
   function automatic logic [31:0] reset_value(input int unsigned idx, input int unsigned width);
      logic [31:0] word;
      word = 32'h0;
      if (idx < BootWords) begin
         word = BootImage[idx[2:0]];
      end
      if (width < 32) begin
         word = word & ((32'h1 << width) - 32'h1);
      end
      return word;
   endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// reg_file_rd_port: one registered read port of the register file.
//   clk, rst_n    : clock, asynchronous active-low reset
//   rd_en         : read strobe; when low the data/busy outputs hold
//   rd_addr       : register to read
//   mem, busy     : flattened storage array and pre-edge busy vector
//   wr_en, wr_addr, wr_data, busy_next : write-back snoop and post-update
//                   busy vector (present only with REG_FILE_BYPASS_EN)
//   rd_data       : registered read data
//   rd_busy       : registered scoreboard flag of the address read
//   rd_valid      : one-cycle pulse after an accepted read
module reg_file_rd_port
   import reg_file_pkg::*;
#(
   parameter int unsigned DATA_W = DefaultDataW,
   parameter int unsigned ADDR_W = DefaultAddrW,
   parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          rd_en,
   input  logic [ADDR_W-1:0]             rd_addr,
   input  logic [DEPTH-1:0][DATA_W-1:0]  mem,
   input  logic [DEPTH-1:0]              busy,
`ifdef REG_FILE_BYPASS_EN
   input  logic                          wr_en,
   input  logic [ADDR_W-1:0]             wr_addr,
   input  logic [DATA_W-1:0]             wr_data,
   input  logic [DEPTH-1:0]              busy_next,
`endif
   output logic [DATA_W-1:0]             rd_data,
   output logic                          rd_busy,
   output logic                          rd_valid
);

   logic [DATA_W-1:0] data_sel;
   logic              busy_sel;

   logic [DATA_W-1:0] data_q, data_d;
   logic              busy_q, busy_d;
   logic              valid_q;

`ifdef REG_FILE_BYPASS_EN
   logic bypass_hit;

   // r0 is never written, so a write to it must not forward.
   assign bypass_hit = wr_en && (wr_addr != '0) && (wr_addr == rd_addr);

   always_comb begin
      data_sel = mem[rd_addr];
      busy_sel = busy[rd_addr];
      if (bypass_hit) begin
         data_sel = wr_data;
         // Post-update value: cleared by the write unless a same-cycle alloc re-sets it.
         busy_sel = busy_next[rd_addr];
      end
   end
`else
   always_comb begin
      data_sel = mem[rd_addr];
      busy_sel = busy[rd_addr];
   end
`endif

   always_comb begin
      data_d = data_q;
      busy_d = busy_q;
      if (rd_en) begin
         data_d = data_sel;
         busy_d = busy_sel;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         busy_q  <= busy_d;
         valid_q <= rd_en;
      end
   end

   assign rd_data  = data_q;
   assign rd_busy  = busy_q;
   assign rd_valid = valid_q;

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-read-port register file with boot image, hardwired zero
// register and per-register busy scoreboard.
//   clk, rst_n  : clock, asynchronous active-low reset (reloads boot image)
//   rd_en       : NRD per-port read strobes
//   rd_addr     : NRD packed addresses, port p at [p*ADDR_W +: ADDR_W]
//   rd_data     : NRD packed registered read data
//   rd_busy     : NRD registered busy flags of the addresses read
//   rd_valid    : NRD one-cycle pulses after accepted reads
//   wr_en, wr_addr, wr_data : write-back; commits data and clears busy
//   alloc_en, alloc_addr    : marks a destination busy
//   busy_any    : registered OR of the post-update busy vector
// Compile-time option: define REG_FILE_BYPASS_EN to forward same-cycle
// write-back data (and post-update busy) to reads of the written register.
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int unsigned DATA_W = DefaultDataW,
   parameter int unsigned ADDR_W = DefaultAddrW,
   parameter int unsigned NRD    = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NRD-1:0]           rd_en,
   input  logic [NRD*ADDR_W-1:0]    rd_addr,
   output logic [NRD*DATA_W-1:0]    rd_data,
   output logic [NRD-1:0]           rd_busy,
   output logic [NRD-1:0]           rd_valid,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     alloc_en,
   input  logic [ADDR_W-1:0]        alloc_addr,
   output logic                     busy_any
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DEPTH-1:0][DATA_W-1:0] mem_q;
   logic [DEPTH-1:0]             busy_q, busy_d;
   logic                         busy_any_q;
   logic                         wr_live;
   logic                         alloc_live;

   // r0 is hardwired: writes and allocs targeting it are dropped here.
   assign wr_live    = wr_en && (wr_addr != '0);
   assign alloc_live = alloc_en && (alloc_addr != '0);

   // Alloc is applied after the write-back clear so a new producer wins.
   always_comb begin
      busy_d = busy_q;
      if (wr_live) begin
         busy_d[wr_addr] = 1'b0;
      end
      if (alloc_live) begin
         busy_d[alloc_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= DATA_W'(reset_value(i, DATA_W));
         end
         busy_q     <= '0;
         busy_any_q <= 1'b0;
      end else begin
         if (wr_live) begin
            mem_q[wr_addr] <= wr_data;
         end
         busy_q     <= busy_d;
         busy_any_q <= |busy_d;
      end
   end

   assign busy_any = busy_any_q;

   for (genvar p = 0; p < NRD; p++) begin : g_rd
      reg_file_rd_port #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W),
         .DEPTH  (DEPTH)
      ) u_rd_port (
         .clk       (clk),
         .rst_n     (rst_n),
         .rd_en     (rd_en[p]),
         .rd_addr   (rd_addr[p*ADDR_W +: ADDR_W]),
         .mem       (mem_q),
         .busy      (busy_q),
`ifdef REG_FILE_BYPASS_EN
         .wr_en     (wr_en),
         .wr_addr   (wr_addr),
         .wr_data   (wr_data),
         .busy_next (busy_d),
`endif
         .rd_data   (rd_data[p*DATA_W +: DATA_W]),
         .rd_busy   (rd_busy[p]),
         .rd_valid  (rd_valid[p])
      );
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed self-checking bench for reg_file_mp (2 read ports,
// 32-bit data, 5-bit addresses). Expected values follow REG_FILE_BYPASS_EN.
module tb_reg_file_mp;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned NRD    = 2;

   logic                  clk;
   logic                  rst_n;
   logic [NRD-1:0]        rd_en;
   logic [NRD*ADDR_W-1:0] rd_addr;
   logic [NRD*DATA_W-1:0] rd_data;
   logic [NRD-1:0]        rd_busy;
   logic [NRD-1:0]        rd_valid;
   logic                  wr_en;
   logic [ADDR_W-1:0]     wr_addr;
   logic [DATA_W-1:0]     wr_data;
   logic                  alloc_en;
   logic [ADDR_W-1:0]     alloc_addr;
   logic                  busy_any;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] img [8];
   logic [31:0] bypass_exp;

   reg_file_mp #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NRD    (NRD)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_busy    (rd_busy),
      .rd_valid   (rd_valid),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .alloc_en   (alloc_en),
      .alloc_addr (alloc_addr),
      .busy_any   (busy_any)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; return 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rd_en    = '0;
      wr_en    = 1'b0;
      alloc_en = 1'b0;
   endtask

   initial begin
      img[0] = 32'h0000_0000;
      img[1] = 32'h0000_000F;
      img[2] = 32'h0000_000C;
      img[3] = 32'hFF00_00FF;
      img[4] = 32'h0000_0004;
      img[5] = 32'h7000_0000;
      img[6] = 32'hF000_0000;
      img[7] = 32'h0000_0000;

      rst_n      = 1'b0;
      rd_en      = '0;
      rd_addr    = '0;
      wr_en      = 1'b0;
      wr_addr    = '0;
      wr_data    = '0;
      alloc_en   = 1'b0;
      alloc_addr = '0;

      #12;
      check("rst_rd_data", 64'(rd_data), 64'h0);
      check("rst_rd_valid", 64'(rd_valid), 64'h0);
      check("rst_rd_busy", 64'(rd_busy), 64'h0);
      check("rst_busy_any", 64'(busy_any), 64'h0);
      rst_n = 1'b1;
      step();

      // Boot image on port 0.
      for (int i = 0; i < 8; i++) begin
         rd_en            = 2'b01;
         rd_addr[4:0]     = 5'(i);
         step();
         check($sformatf("boot_r%0d_data", i), 64'(rd_data[31:0]), 64'(img[i]));
         check($sformatf("boot_r%0d_busy", i), 64'(rd_busy[0]), 64'h0);
         check($sformatf("boot_r%0d_valid", i), 64'(rd_valid), 64'h1);
      end

      // Write r9, then read it on both ports.
      idle_inputs();
      wr_en   = 1'b1;
      wr_addr = 5'd9;
      wr_data = 32'hDEAD_BEEF;
      step();
      idle_inputs();
      rd_en   = 2'b11;
      rd_addr = {5'd9, 5'd9};
      step();
      check("wr_r9_p0", 64'(rd_data[31:0]), 64'hDEAD_BEEF);
      check("wr_r9_p1", 64'(rd_data[63:32]), 64'hDEAD_BEEF);
      check("wr_r9_valid", 64'(rd_valid), 64'h3);
      rd_en   = 2'b00;
      rd_addr = {5'd1, 5'd1};
      step();
      check("hold_valid", 64'(rd_valid), 64'h0);
      check("hold_p0_data", 64'(rd_data[31:0]), 64'hDEAD_BEEF);

      // Zero register: write and alloc r0 together.
      wr_en      = 1'b1;
      wr_addr    = 5'd0;
      wr_data    = 32'h1234_5678;
      alloc_en   = 1'b1;
      alloc_addr = 5'd0;
      step();
      idle_inputs();
      rd_en   = 2'b01;
      rd_addr = {5'd0, 5'd0};
      step();
      check("r0_data", 64'(rd_data[31:0]), 64'h0);
      check("r0_busy", 64'(rd_busy[0]), 64'h0);
      check("r0_busy_any", 64'(busy_any), 64'h0);

      // Scoreboard: alloc r5, read busy, then commit it.
      idle_inputs();
      alloc_en   = 1'b1;
      alloc_addr = 5'd5;
      step();
      idle_inputs();
      rd_en   = 2'b01;
      rd_addr = {5'd0, 5'd5};
      step();
      check("sb_r5_data", 64'(rd_data[31:0]), 64'h7000_0000);
      check("sb_r5_busy", 64'(rd_busy[0]), 64'h1);
      check("sb_busy_any", 64'(busy_any), 64'h1);
      idle_inputs();
      wr_en   = 1'b1;
      wr_addr = 5'd5;
      wr_data = 32'h1;
      step();
      check("sb_commit_busy_any", 64'(busy_any), 64'h0);
      idle_inputs();
      rd_en   = 2'b01;
      rd_addr = {5'd0, 5'd5};
      step();
      check("sb_r5_new_data", 64'(rd_data[31:0]), 64'h1);
      check("sb_r5_new_busy", 64'(rd_busy[0]), 64'h0);
      check("sb_idle_busy_any", 64'(busy_any), 64'h0);

      // Collision: alloc and write r3 in one cycle.
      idle_inputs();
      alloc_en   = 1'b1;
      alloc_addr = 5'd3;
      wr_en      = 1'b1;
      wr_addr    = 5'd3;
      wr_data    = 32'hAA;
      step();
      idle_inputs();
      rd_en   = 2'b10;
      rd_addr = {5'd3, 5'd0};
      step();
      check("col_r3_data", 64'(rd_data[63:32]), 64'hAA);
      check("col_r3_busy", 64'(rd_busy[1]), 64'h1);
      check("col_busy_any", 64'(busy_any), 64'h1);
      check("col_p1_valid_only", 64'(rd_valid), 64'h2);
      idle_inputs();
      wr_en   = 1'b1;
      wr_addr = 5'd3;
      wr_data = 32'hAA;
      step();
      check("col_clear_busy_any", 64'(busy_any), 64'h0);

      // Same-cycle read of the register being written.
`ifdef REG_FILE_BYPASS_EN
      bypass_exp = 32'h55;
`else
      bypass_exp = 32'hC;
`endif
      idle_inputs();
      rd_en   = 2'b01;
      rd_addr = {5'd0, 5'd2};
      wr_en   = 1'b1;
      wr_addr = 5'd2;
      wr_data = 32'h55;
      step();
      check("byp_r2_data", 64'(rd_data[31:0]), 64'(bypass_exp));
      check("byp_r2_busy", 64'(rd_busy[0]), 64'h0);
      idle_inputs();
      rd_en   = 2'b11;
      rd_addr = {5'd9, 5'd2};
      step();
      check("after_wr_r2", 64'(rd_data[31:0]), 64'h55);
      check("after_wr_r9", 64'(rd_data[63:32]), 64'hDEAD_BEEF);

      // Asynchronous reset in the middle of a read burst.
      step();
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_rd_data", 64'(rd_data), 64'h0);
      check("mid_rst_rd_valid", 64'(rd_valid), 64'h0);
      check("mid_rst_busy_any", 64'(busy_any), 64'h0);
      rst_n = 1'b1;
      step();
      check("post_rst_r2", 64'(rd_data[31:0]), 64'hC);
      check("post_rst_r9", 64'(rd_data[63:32]), 64'h0);
      check("post_rst_valid", 64'(rd_valid), 64'h3);

      idle_inputs();
      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port register file for the 32-bit datapath, with a preloaded boot image, a hardwired zero register, and a per-register busy scoreboard. It sits between decode and the ALU. Decode allocates destinations, the read ports supply registered operands with busy flags, and write-back commits results and clears busy. Optional write-to-read bypass is selectable at compile time.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth is 2**ADDR_W
- NRD, 2, number of read ports (1..4)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- rd_en  in  NRD  per-port read strobe
- rd_addr  in  NRD*ADDR_W  per-port read address; port p occupies bits [p*ADDR_W +: ADDR_W]
- rd_data  out  NRD*DATA_W  per-port registered read data
- rd_busy  out  NRD  per-port registered scoreboard flag for the address read
- rd_valid  out  NRD  high for one cycle after an accepted rd_en
- wr_en  in  1  write-back strobe
- wr_addr  in  ADDR_W  write-back address
- wr_data  in  DATA_W  write-back data
- alloc_en  in  1  mark a destination register busy
- alloc_addr  in  ADDR_W  register to mark busy
- busy_any  out  1  registered; high while any busy bit is set

## Operation
- **Storage:** 2**ADDR_W registers.
  - Register 0 always reads 0. Writes to it are ignored, and alloc to it is ignored, so it is never busy.
- **Reset image:** rst_n low loads the boot image.
  - r0=0x00000000, r1=0x0000000F, r2=0x0000000C, r3=0xFF0000FF, r4=0x00000004, r5=0x70000000, r6=0xF0000000.
  - All other registers load 0.
  - For DATA_W<32 the image is truncated to the low bits; for DATA_W>32 it is zero-extended.
- **Reset of outputs and scoreboard:** rst_n low also clears all busy bits. rd_data=0, rd_busy=0, rd_valid=0 and busy_any=0.
- **Reads:** on a clock edge with rd_en[p]=1, port p captures mem[rd_addr_p] into rd_data_p and busy[rd_addr_p] into rd_busy_p, and sets rd_valid_p=1.
  - With rd_en[p]=0, rd_data_p and rd_busy_p hold their previous values and rd_valid_p=0.
- **Writes:** on a clock edge with wr_en=1 and wr_addr≠0, mem[wr_addr] takes wr_data and busy[wr_addr] clears.
- **Allocation:** on a clock edge with alloc_en=1 and alloc_addr≠0, busy[alloc_addr] sets.
- **Alloc and write to the same register in one cycle:** alloc wins and the busy bit ends set, because a new producer supersedes the committing one. The data is still written.
- **Multiple ports at the same address:** read ports are independent, so all ports may read the same address in the same cycle.
- **Same-cycle read of the register being written:** see Configuration.
  - The rd_busy sampled in that case reflects the pre-edge busy bit, unless REG_FILE_BYPASS_EN is defined.
- **busy_any:** the registered OR of the post-update busy vector.

## Timing
- **Read latency:** 1 cycle. Address at edge N gives data, busy flag and rd_valid after edge N.
- **Write visibility:** a write at edge N is visible to reads issued at edge N+1 (data after edge N+1).
- **Allocation visibility:** alloc at edge N makes busy visible to reads issued at edge N+1.
- **Reset:** asserting rst_n mid-operation takes effect immediately and asynchronously.
  - Outputs go to their reset values without a clock, and in-flight reads are discarded.
  - The first read accepted after deassertion returns boot-image values.
- **Throughput:** one read per port per cycle, one write per cycle and one alloc per cycle, all concurrent, with no stalls inside the block.

## Configuration
- The feature is selected by the macro REG_FILE_BYPASS_EN.
- **Defined:** a read at edge N whose address equals a non-zero wr_addr with wr_en=1 returns wr_data.
  - Its rd_busy equals the post-update busy value, i.e. 0 unless a same-cycle alloc hits that address.
- **Undefined:** the same read returns the pre-write stored value and the pre-edge busy bit. Software and the pipeline must then insert one cycle between write-back and a dependent read.

## Structure
- **Shared package reg_file_pkg:**
  - default DATA_W and ADDR_W constants
  - a 32-bit boot-image constant array for r0..r6
  - a function returning the reset value for a given index and width
- **Sub-module reg_file_rd_port:** instantiated NRD times via generate. Each instance holds:
  - the address mux
  - the bypass compare (under the macro)
  - the rd_data/rd_busy/rd_valid output registers
- **Top level:** holds the storage array, the busy vector, write/alloc update logic and busy_any.

## Test plan
- **Reset image:** assert rst_n low, release it, then read r0..r7 on port 0 → 0, 0xF, 0xC, 0xFF0000FF, 0x4, 0x70000000, 0xF0000000, 0; rd_busy=0 throughout.
- **Write then read:** write r9=0xDEADBEEF, read r9 on both ports the next cycle → both return 0xDEADBEEF one cycle later with rd_valid=11.
- **Zero register:** write r0=0x12345678 with alloc r0 in the same cycle → a later read of r0 returns 0, rd_busy=0, busy_any=0.
- **Scoreboard:**
  - alloc r5, then read r5 → rd_busy=1 with data 0x70000000, and busy_any=1.
  - Write r5=0x1 → the next read gives rd_busy=0, data 0x1, and busy_any=0.
- **Collision:** alloc r3 and write r3=0xAA in the same cycle → a read the next cycle returns 0xAA with rd_busy=1.
- **Bypass and reset:**
  - Read r2 in the same cycle as a write r2=0x55 → 0x55 with the macro defined, 0xC without it.
  - Pulse rst_n low mid-burst → outputs are 0 immediately, and r2 reads 0xC afterwards.
